// File: rtl/camera_frame_ctrl.sv
// Frame-level capture sequencer for the camera pixel path: arm, skip, N-shot/continuous capture, line checks.
// Optional hsync watchdog enabled by defining CAM_FRAME_TIMEOUT_EN.
module camera_frame_ctrl #(
    parameter int FRM_W     = 8,
    parameter int LINE_W    = 16,
    parameter int TIMEOUT_W = 16
) (
    input  logic              s_cam_clk_dft,
    input  logic              rstn_i,
    input  logic              cfg_en_i,
    input  logic [FRM_W-1:0]  cfg_frames_i,
    input  logic [FRM_W-1:0]  cfg_skip_i,
    input  logic [LINE_W-1:0] cfg_rowlen_i,
    input  logic              cam_vsync_i,
    input  logic              cam_hsync_i,
    input  logic              pix_valid_i,
    input  logic              fifo_ready_i,
    output logic              capture_en_o,
    output logic              sof_o,
    output logic              eof_o,
    output logic              busy_o,
    output logic [FRM_W-1:0]  frame_cnt_o,
    output logic [LINE_W-1:0] line_cnt_o,
    output logic              err_linelen_o,
    output logic              err_ovf_o,
    output logic              err_timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_SKIP,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state;
    logic              en_meta;
    logic              en_s;
    logic              r_vsync;
    logic              r_hsync;
    logic [FRM_W-1:0]  frames_q;
    logic [FRM_W-1:0]  skip_q;
    logic [LINE_W-1:0] rowlen_q;
    logic [FRM_W-1:0]  skip_cnt;
    logic [LINE_W-1:0] pix_cnt;

    logic              sof;
    logic              eof;
    logic              hs_fall;
    logic              hs_edge;
    logic              arm;
    logic              start;
    logic              in_cap;
    logic              wd_expire;
    logic [FRM_W-1:0]  frame_inc;
    logic [LINE_W-1:0] row_exp;

    assign sof       = !r_vsync && cam_vsync_i;
    assign eof       = r_vsync && !cam_vsync_i;
    assign hs_fall   = r_hsync && !cam_hsync_i;
    assign hs_edge   = r_hsync ^ cam_hsync_i;
    assign arm       = en_s && (state == S_IDLE);
    assign start     = en_s && (state == S_WAIT_SOF) && sof && (skip_cnt == skip_q);
    assign in_cap    = (state == S_CAPTURE);
    assign frame_inc = frame_cnt_o + FRM_W'(1);
    assign row_exp   = rowlen_q + LINE_W'(1);

    // Two-flop synchroniser: cfg_en_i comes from the system clock domain.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i) begin
            en_meta <= 1'b0;
            en_s    <= 1'b0;
        end else begin
            en_meta <= cfg_en_i;
            en_s    <= en_meta;
        end
    end

`ifdef CAM_FRAME_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_cnt;

    // Counter is held at zero outside CAPTURE, so entry on sof always starts it fresh.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i) begin
            wd_cnt        <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            if (!in_cap || hs_edge) begin
                wd_cnt <= '0;
            end else if (wd_cnt != '1) begin
                wd_cnt <= wd_cnt + TIMEOUT_W'(1);
            end
            if (arm) begin
                err_timeout_o <= 1'b0;
            end else if (in_cap && en_s && !eof && wd_expire) begin
                err_timeout_o <= 1'b1;
            end
        end
    end

    assign wd_expire = in_cap && !hs_edge && (wd_cnt == '1);
`else
    logic [TIMEOUT_W-1:0] wd_unused;

    assign wd_unused     = '0;
    assign wd_expire     = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    // Frame sequencer; every output is updated together with the state it reflects.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= S_IDLE;
            capture_en_o <= 1'b0;
            sof_o        <= 1'b0;
            eof_o        <= 1'b0;
            busy_o       <= 1'b0;
            frame_cnt_o  <= '0;
            skip_cnt     <= '0;
            frames_q     <= '0;
            skip_q       <= '0;
            rowlen_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values;
            // blocking would let later statements see already-updated state within the same edge.
            sof_o <= 1'b0;
            eof_o <= 1'b0;
            if (!en_s) begin
                state        <= S_IDLE;
                capture_en_o <= 1'b0;
                busy_o       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state       <= S_WAIT_SOF;
                        busy_o      <= 1'b1;
                        frame_cnt_o <= '0;
                        skip_cnt    <= '0;
                        frames_q    <= cfg_frames_i;
                        skip_q      <= cfg_skip_i;
                        rowlen_q    <= cfg_rowlen_i;
                    end
                    S_WAIT_SOF: begin
                        if (sof) begin
                            if (skip_cnt == skip_q) begin
                                state        <= S_CAPTURE;
                                skip_cnt     <= '0;
                                sof_o        <= 1'b1;
                                capture_en_o <= 1'b1;
                            end else begin
                                state    <= S_SKIP;
                                skip_cnt <= skip_cnt + FRM_W'(1);
                            end
                        end
                    end
                    S_SKIP: begin
                        if (eof) begin
                            state <= S_WAIT_SOF;
                        end
                    end
                    S_CAPTURE: begin
                        if (eof) begin
                            eof_o        <= 1'b1;
                            capture_en_o <= 1'b0;
                            frame_cnt_o  <= frame_inc;
                            if ((frames_q != '0) && (frame_inc == frames_q)) begin
                                state  <= S_DONE;
                                busy_o <= 1'b0;
                            end else begin
                                state <= S_WAIT_SOF;
                            end
                        end else if (wd_expire) begin
                            state        <= S_WAIT_SOF;
                            capture_en_o <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        state <= S_DONE;
                    end
                    default: begin
                        state        <= S_IDLE;
                        capture_en_o <= 1'b0;
                        busy_o       <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Line tracking and sticky errors; pixel/line counters only move while capturing.
    always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
        if (!rstn_i) begin
            r_vsync       <= 1'b0;
            r_hsync       <= 1'b0;
            pix_cnt       <= '0;
            line_cnt_o    <= '0;
            err_linelen_o <= 1'b0;
            err_ovf_o     <= 1'b0;
        end else begin
            r_vsync <= cam_vsync_i;
            r_hsync <= cam_hsync_i;
            if (arm) begin
                err_linelen_o <= 1'b0;
                err_ovf_o     <= 1'b0;
            end else if (start) begin
                pix_cnt    <= '0;
                line_cnt_o <= '0;
            end else if (in_cap) begin
                if (hs_fall) begin
                    line_cnt_o <= line_cnt_o + LINE_W'(1);
                    pix_cnt    <= '0;
                    if (pix_cnt != row_exp) begin
                        err_linelen_o <= 1'b1;
                    end
                end else if (cam_hsync_i && pix_valid_i) begin
                    pix_cnt <= pix_cnt + LINE_W'(1);
                end
                if (pix_valid_i && !fifo_ready_i) begin
                    err_ovf_o <= 1'b1;
                end
            end
        end
    end

endmodule
